// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel position from looped-back h_sync/v_sync, measures line and frame
// timing, declares lock and samples the colour at a probe point. Define FRAME_CHECKSUM_EN to add frame_sum.
module vga_sync_receiver #(
   parameter int LOCK_FRAMES = 2,
   parameter int CNT_MAX     = 1023
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        h_sync,
   input  logic        v_sync,
   input  logic [3:0]  red_in,
   input  logic [3:0]  green_in,
   input  logic [3:0]  blue_in,
   input  logic [9:0]  probe_x,
   input  logic [9:0]  probe_y,
   output logic [9:0]  x_pos,
   output logic [9:0]  y_pos,
   output logic [9:0]  line_len,
   output logic [9:0]  frame_lines,
   output logic        locked,
   output logic        frame_start,
   output logic        sync_error,
   output logic [11:0] probe_rgb,
   output logic        probe_valid
`ifdef FRAME_CHECKSUM_EN
   ,
   output logic [15:0] frame_sum
`endif
);

   localparam logic [9:0] CNT_LIM = 10'(CNT_MAX);
   localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

   localparam logic [1:0] ST_SEARCH  = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_VERIFY  = 2'd2;
   localparam logic [1:0] ST_LOCKED  = 2'd3;

   function automatic logic [9:0] sat_inc(input logic [9:0] v);
      return (v >= CNT_LIM) ? CNT_LIM : v + 10'd1;
   endfunction

   logic        h_sync_p0, h_sync_p1, v_sync_p0, v_sync_p1;
   logic [11:0] rgb_p0, rgb_p1;
   logic [9:0]  h_cnt, v_cnt;
   logic [1:0]  state;
   logic [3:0]  good_cnt;
   logic [9:0]  ref_len, ref_lines;
   logic        ref_len_set, seen_h;

   logic        hrise, vrise, len_valid, len_err, lines_err, timeout, err;
   logic [9:0]  cur_len, cur_lines;
   logic [3:0]  good_next;

   assign x_pos = h_cnt;
   assign y_pos = v_cnt;

   // stage 1: edge detection and measurement on the registered syncs
   assign hrise     = h_sync_p0 & ~h_sync_p1;
   assign vrise     = v_sync_p0 & ~v_sync_p1;
   assign cur_len   = h_cnt + 10'd1;
   assign cur_lines = v_cnt + {9'd0, hrise};
   assign len_valid = hrise & seen_h;
   assign len_err   = len_valid & ref_len_set & (cur_len != ref_len);
   assign lines_err = vrise & ((state == ST_VERIFY) | (state == ST_LOCKED)) & (cur_lines != ref_lines);
   assign timeout   = (h_cnt == CNT_LIM) | (v_cnt == CNT_LIM);
   assign err       = (state != ST_SEARCH) & (len_err | lines_err | timeout);
   assign good_next = good_cnt + 4'd1;

   always_ff @(posedge clock) begin
      if (!reset) begin
         h_sync_p0   <= 1'b0;
         h_sync_p1   <= 1'b0;
         v_sync_p0   <= 1'b0;
         v_sync_p1   <= 1'b0;
         rgb_p0      <= '0;
         rgb_p1      <= '0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         state       <= ST_SEARCH;
         good_cnt    <= '0;
         ref_len     <= '0;
         ref_lines   <= '0;
         ref_len_set <= 1'b0;
         seen_h      <= 1'b0;
         line_len    <= '0;
         frame_lines <= '0;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         sync_error  <= 1'b0;
         probe_rgb   <= '0;
         probe_valid <= 1'b0;
      end else begin
         h_sync_p0   <= h_sync;
         h_sync_p1   <= h_sync_p0;
         v_sync_p0   <= v_sync;
         v_sync_p1   <= v_sync_p0;
         rgb_p0      <= {red_in, green_in, blue_in};
         // second colour stage lines the pixel up with the counter value it belongs to
         rgb_p1      <= rgb_p0;
         h_cnt       <= hrise ? 10'd0 : sat_inc(h_cnt);
         v_cnt       <= vrise ? 10'd0 : (hrise ? sat_inc(v_cnt) : v_cnt);
         frame_start <= vrise;
         sync_error  <= err;
         probe_valid <= 1'b0;

         if (err) begin
            state       <= ST_SEARCH;
            locked      <= 1'b0;
            good_cnt    <= '0;
            seen_h      <= 1'b0;
            ref_len_set <= 1'b0;
         end else begin
            if (hrise)
               seen_h <= 1'b1;
            if (len_valid && !ref_len_set) begin
               ref_len     <= cur_len;
               ref_len_set <= 1'b1;
            end
            if (len_valid && state != ST_SEARCH)
               line_len <= cur_len;

            case (state)
               ST_SEARCH: begin
                  if (vrise)
                     state <= ST_MEASURE;
               end
               ST_MEASURE: begin
                  if (vrise) begin
                     ref_lines   <= cur_lines;
                     frame_lines <= cur_lines;
                     good_cnt    <= 4'd1;
                     if (LOCK_N <= 4'd1) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                     end else begin
                        state <= ST_VERIFY;
                     end
                  end
               end
               ST_VERIFY: begin
                  if (vrise) begin
                     frame_lines <= cur_lines;
                     good_cnt    <= good_next;
                     if (good_next >= LOCK_N) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                     end
                  end
               end
               default: begin
                  if (vrise)
                     frame_lines <= cur_lines;
               end
            endcase

            // probe points outside the measured raster can never match
            if (locked && h_cnt == probe_x && v_cnt == probe_y &&
                probe_x < ref_len && probe_y < ref_lines) begin
               probe_rgb   <= rgb_p1;
               probe_valid <= 1'b1;
            end
         end
      end
   end

`ifdef FRAME_CHECKSUM_EN
   logic [15:0] sum_acc;

   // accumulator runs on the same stage as vrise so the new frame starts with its own first pixel
   always_ff @(posedge clock) begin
      if (!reset) begin
         sum_acc   <= '0;
         frame_sum <= '0;
      end else if (state == ST_SEARCH) begin
         frame_sum <= '0;
         sum_acc   <= vrise ? {4'd0, rgb_p0} : 16'd0;
      end else if (vrise) begin
         frame_sum <= sum_acc;
         sum_acc   <= {4'd0, rgb_p0};
      end else begin
         sum_acc   <= sum_acc + {4'd0, rgb_p0};
      end
   end
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a reduced 40x12 raster; event scoreboard for frame_start,
// sync_error and probe_valid plus directed state checks.
module tb_vga_sync_receiver;

   localparam int HT = 40;
   localparam int HS = 4;
   localparam int VT = 12;
   localparam int VS = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        h_sync, v_sync;
   logic [3:0]  red_in, green_in, blue_in;
   logic [9:0]  probe_x, probe_y;
   logic [9:0]  x_pos, y_pos, line_len, frame_lines;
   logic        locked, frame_start, sync_error, probe_valid;
   logic [11:0] probe_rgb;
`ifdef FRAME_CHECKSUM_EN
   logic [15:0] frame_sum;
`endif

   always #20 clock = ~clock;

   vga_sync_receiver #(.LOCK_FRAMES(2), .CNT_MAX(1023)) dut (
      .clock(clock), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .probe_x(probe_x), .probe_y(probe_y),
      .x_pos(x_pos), .y_pos(y_pos), .line_len(line_len), .frame_lines(frame_lines),
      .locked(locked), .frame_start(frame_start), .sync_error(sync_error),
      .probe_rgb(probe_rgb), .probe_valid(probe_valid)
`ifdef FRAME_CHECKSUM_EN
      , .frame_sum(frame_sum)
`endif
   );

   int tests = 0;
   int fails = 0;
   int ncnt  = 0;
   int last_hrise = 0;
   int mdl_st = 0;
   int mdl_good = 0;
   int fs_q[$];
   int err_q[$];
   int pr_t_q[$];
   logic [11:0] pr_v_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance to the next falling edge and retire any output events against the scoreboard
   task automatic tick();
      int t;
      logic [11:0] v;
      @(negedge clock);
      ncnt++;
      if (frame_start) begin
         chk("frame_start_expected", fs_q.size() > 0, 1);
         if (fs_q.size() > 0) begin
            t = fs_q.pop_front();
            chk("frame_start_cycle", ncnt, t);
         end
      end
      if (sync_error) begin
         chk("sync_error_expected", err_q.size() > 0, 1);
         if (err_q.size() > 0) begin
            t = err_q.pop_front();
            chk("sync_error_cycle", ncnt, t);
         end
      end
      if (probe_valid) begin
         chk("probe_valid_expected", pr_t_q.size() > 0, 1);
         if (pr_t_q.size() > 0) begin
            t = pr_t_q.pop_front();
            v = pr_v_q.pop_front();
            chk("probe_valid_cycle", ncnt, t);
            chk("probe_rgb_value", probe_rgb, v);
         end
      end
   endtask

   task automatic drive(input logic hs, input logic vs, input logic [11:0] c);
      h_sync = hs;
      v_sync = vs;
      {red_in, green_in, blue_in} = c;
   endtask

   task automatic model_vrise();
      case (mdl_st)
         0: mdl_st = 1;
         1: begin mdl_st = 2; mdl_good = 1; end
         2: begin
            mdl_good++;
            if (mdl_good >= 2) mdl_st = 3;
         end
         default: mdl_st = 3;
      endcase
   endtask

   // one frame; short_line gets HT-1 clocks, rst_line pulses reset at x=20 of that line
   task automatic send_frame(input int short_line, input int rst_line, input logic [11:0] c);
      bit pend_short = 0;
      bit pend_rst = 0;
      for (int y = 0; y < VT; y++) begin
         for (int x = 0; x < ((y == short_line) ? HT - 1 : HT); x++) begin
            tick();
            if (pend_rst) begin
               chk("rst_pos", {x_pos, y_pos}, 0);
               chk("rst_meas", {line_len, frame_lines}, 0);
               chk("rst_flags", {locked, frame_start, sync_error, probe_valid}, 0);
               chk("rst_probe_rgb", probe_rgb, 0);
               reset = 1'b1;
               pend_rst = 0;
            end
            if (x == 0) begin
               last_hrise = ncnt;
               if (y == 0) begin
                  fs_q.push_back(ncnt + 2);
                  model_vrise();
               end
               if (pend_short) begin
                  if (mdl_st != 0) begin
                     err_q.push_back(ncnt + 2);
                     mdl_st = 0;
                     mdl_good = 0;
                  end
                  pend_short = 0;
               end
            end
            if (mdl_st == 3 && x == int'(probe_x) && y == int'(probe_y)) begin
               pr_t_q.push_back(ncnt + 3);
               pr_v_q.push_back(c);
            end
            if (y == rst_line && x == 20) begin
               reset = 1'b0;
               pend_rst = 1;
               mdl_st = 0;
               mdl_good = 0;
            end
            drive(x < HS, y < VS, c);
         end
         if (y == short_line) pend_short = 1;
      end
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 1'b0, 12'h000);
      probe_x = 10'd20;
      probe_y = 10'd5;
      repeat (3) tick();
      chk("reset_x_pos", x_pos, 0);
      chk("reset_locked", locked, 0);
      chk("reset_line_len", line_len, 0);
      chk("reset_probe_rgb", probe_rgb, 0);
      reset = 1'b1;

      send_frame(-1, -1, 12'h001);
      send_frame(-1, -1, 12'h001);
`ifdef FRAME_CHECKSUM_EN
      chk("frame_sum", frame_sum, HT * VT);
`endif
      chk("not_locked_2_vrise", locked, 0);
      chk("line_len", line_len, HT);
      chk("frame_lines", frame_lines, VT);

      send_frame(-1, -1, 12'h0F0);
      chk("locked_3rd_vrise", locked, 1);
      chk("probe_green", probe_rgb, 12'h0F0);
      send_frame(-1, -1, 12'h0F0);

      send_frame(3, -1, 12'h0F0);
      chk("unlock_short_line", locked, 0);
      chk("frame_lines_hold", frame_lines, VT);
      send_frame(-1, -1, 12'h0F0);
      send_frame(-1, -1, 12'h0F0);
      chk("relock_not_yet", locked, 0);
      probe_x = 10'd30;
      probe_y = 10'd8;
      send_frame(-1, -1, 12'hF00);
      chk("relock", locked, 1);
      chk("probe_moved", probe_rgb, 12'hF00);
      chk("line_len_relock", line_len, HT);

      probe_x = 10'd45;
      send_frame(-1, 6, 12'h00F);
      chk("unlock_after_reset", locked, 0);
      send_frame(-1, -1, 12'h00F);
      send_frame(-1, -1, 12'h00F);
      chk("reset_relock_not_yet", locked, 0);
      probe_x = 10'd20;
      probe_y = 10'd5;
      send_frame(-1, -1, 12'h00F);
      chk("reset_relock", locked, 1);
      chk("probe_blue", probe_rgb, 12'h00F);

      drive(1'b0, 1'b0, 12'h00F);
      err_q.push_back(last_hrise + 1026);
      for (int i = 0; i < 1200 && err_q.size() > 0; i++) tick();
      chk("timeout_error_seen", err_q.size(), 0);
      repeat (2) tick();
      chk("timeout_unlocked", locked, 0);
      chk("x_pos_saturated", x_pos, 1023);
      chk("y_pos_held", y_pos, VT - 1);

      chk("frame_start_all_seen", fs_q.size(), 0);
      chk("probe_all_seen", pr_t_q.size(), 0);
      chk("sync_error_all_seen", err_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
